// File: rtl/dsm_dac_param.sv
// Delta-sigma DAC with a selectable 1st/2nd order loop and generic widths.
// Samples arrive through a one-entry valid/ready buffer and are paced every OSR ticks.
module dsm_dac_param #(
  parameter int WIDTH = 16,
  parameter int EXT   = 4,
  parameter int ORDER = 2,
  parameter int OSR   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mute,
  input  logic             flag_clr,
  output logic             dsm_out,
  output logic             underrun,
  output logic             overload
);

  localparam int A  = WIDTH + EXT;
  localparam int CW = $clog2(OSR);
  localparam logic [A-1:0]  FB_POS   = A'(2 ** (WIDTH - 1));
  localparam logic [A-1:0]  FB_NEG   = A'(-(2 ** (WIDTH - 1)));
  localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

  generate
    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
      $error("dsm_dac_param: ORDER must be 1 or 2");
    end
    if (OSR < 2) begin : g_bad_osr
      $error("dsm_dac_param: OSR must be at least 2");
    end
  endgenerate

  logic [A-1:0]     acc1;
  logic [A-1:0]     acc2;
  logic [A-1:0]     x;
  logic [A-1:0]     fb;
  logic [A-1:0]     acc1n;
  logic [A-1:0]     acc2n;
  logic [A-1:0]     d;
  logic [WIDTH-1:0] pend_data;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] cur;
  logic [CW-1:0]    osr_cnt;
  logic             pend_valid;
  logic             primed;
  logic             load;
  logic             accept;
  logic             ovf;

  assign in_ready = ~pend_valid;
  assign accept   = in_valid & ~pend_valid;
  assign load     = clk_en & (osr_cnt == '0);

  // A sample promoted at a load slot feeds the loop on that very tick.
  assign cur   = (load & pend_valid) ? pend_data : active;
  assign x     = mute ? '0 : {{EXT{cur[WIDTH-1]}}, cur};
  assign fb    = dsm_out ? FB_POS : FB_NEG;
  assign acc1n = acc1 + x - fb;
  assign acc2n = acc2 + acc1n - fb;
  assign d     = (ORDER == 2) ? acc2n : acc1n;
  assign ovf   = d[A-1] ^ d[A-2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      osr_cnt    <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      active     <= '0;
      primed     <= 1'b0;
    end else begin
      if (clk_en) begin
        osr_cnt <= (osr_cnt == CNT_LAST) ? '0 : osr_cnt + 1'b1;
      end
      if (load & pend_valid) begin
        active     <= pend_data;
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend_data  <= in_data;
        pend_valid <= 1'b1;
      end
      if (accept) begin
        primed <= 1'b1;
      end
    end
  end

  // An out-of-range decision value restarts the loop from a clean state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc1    <= '0;
      acc2    <= '0;
      dsm_out <= 1'b0;
    end else if (clk_en) begin
      if (ovf) begin
        acc1    <= '0;
        acc2    <= '0;
        dsm_out <= 1'b0;
      end else begin
        acc1    <= acc1n;
        acc2    <= (ORDER == 2) ? acc2n : '0;
        dsm_out <= ~d[A-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun <= 1'b0;
      overload <= 1'b0;
    end else begin
      underrun <= (load & ~pend_valid & primed) | (underrun & ~flag_clr);
      overload <= (clk_en & ovf) | (overload & ~flag_clr);
    end
  end

endmodule
